// File: rtl/mem_arb.sv
// mem_arb: shares one memory port between instruction fetch and the LSU.
// Data requests normally win. A starvation counter forces a fetch grant after
// STARVE_MAX data grants made while fetch was waiting. A fetch flush discards
// the result of an in-flight fetch but still lets that access complete.
module mem_arb #(
    parameter int LATENCY    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    input  logic        if_flush,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [15:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        if_ack,
    output logic        ls_ack,
    output logic [31:0] rd_data,
    output logic        busy
);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t        state;
    logic          owner_if;    // 1 = current access belongs to fetch
    logic          drop;        // fetch result flushed while in flight
    logic [CW-1:0] cnt;
    logic [SW-1:0] starve_cnt;

    logic if_elig, ls_elig, starved, grant_if, grant_ls;

    // Arbitration: a requester is masked in its own ack cycle so a held
    // request is not re-granted before the requester has seen the ack.
    always_comb begin
        if_elig  = if_req & ~if_ack & ~if_flush;
        ls_elig  = ls_req & ~ls_ack;
        starved  = (starve_cnt == SW'(STARVE_MAX));
        grant_if = if_elig & (~ls_elig | starved);
        grant_ls = ls_elig & ~grant_if;
    end

    // Single-process FSM; all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner_if   <= 1'b0;
            drop       <= 1'b0;
            cnt        <= '0;
            starve_cnt <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_ack     <= 1'b0;
            ls_ack     <= 1'b0;
            rd_data    <= '0;
            busy       <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            ls_ack <= 1'b0;
            case (state)
                IDLE: begin
                    drop <= 1'b0;
                    if (grant_if) begin
                        owner_if   <= 1'b1;
                        mem_addr   <= if_addr;
                        mem_we     <= 1'b0;
                        mem_wdata  <= '0;
                        mem_en     <= 1'b1;
                        busy       <= 1'b1;
                        cnt        <= CW'(LATENCY - 1);
                        starve_cnt <= '0;
                        state      <= ACCESS;
                    end else if (grant_ls) begin
                        owner_if  <= 1'b0;
                        mem_addr  <= ls_addr;
                        mem_we    <= ls_we;
                        mem_wdata <= ls_wdata;
                        mem_en    <= 1'b1;
                        busy      <= 1'b1;
                        cnt       <= CW'(LATENCY - 1);
                        state     <= ACCESS;
                        if (if_req) begin
                            if (!starved)
                                starve_cnt <= starve_cnt + 1'b1;
                        end else begin
                            starve_cnt <= '0;
                        end
                    end else if (!if_req) begin
                        starve_cnt <= '0;
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        rd_data <= mem_rdata;
                        if (owner_if)
                            if_ack <= ~(drop | if_flush);
                        else
                            ls_ack <= 1'b1;
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        busy   <= 1'b0;
                        drop   <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                        if (owner_if && if_flush)
                            drop <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: cycle-by-cycle vector table for mem_arb plus a hand-written
// starvation sequence. Row i holds the inputs driven in cycle i and the
// outputs expected during that same cycle.
module tb_mem_arb;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, ls_req, ls_we;
    logic [15:0] if_addr, ls_addr;
    logic [31:0] ls_wdata, mem_rdata;
    logic        mem_en, mem_we, if_ack, ls_ack, busy;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, rd_data;

    int n_chk  = 0;
    int n_fail = 0;

    mem_arb #(.LATENCY(2), .STARVE_MAX(3)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .if_ack(if_ack), .ls_ack(ls_ack),
        .rd_data(rd_data), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, ifr;
        logic [15:0] ifa;
        logic        ifl, lsr, lwe;
        logic [15:0] lsa;
        logic [31:0] lwd, mrd;
        logic        en, we;
        logic [15:0] addr;
        logic [31:0] wd;
        logic        ia, la;
        logic [31:0] rdd;
        logic        bsy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic rst_i, input logic ifr, input logic [15:0] ifa, input logic ifl,
        input logic lsr, input logic lwe, input logic [15:0] lsa, input logic [31:0] lwd,
        input logic [31:0] mrd,
        input logic en, input logic we, input logic [15:0] addr, input logic [31:0] wd,
        input logic ia, input logic la, input logic [31:0] rdd, input logic bsy);
        vec_t v;
        v.rst = rst_i; v.ifr = ifr; v.ifa = ifa; v.ifl = ifl;
        v.lsr = lsr; v.lwe = lwe; v.lsa = lsa; v.lwd = lwd; v.mrd = mrd;
        v.en = en; v.we = we; v.addr = addr; v.wd = wd;
        v.ia = ia; v.la = la; v.rdd = rdd; v.bsy = bsy;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rst = v.rst; if_req = v.ifr; if_addr = v.ifa; if_flush = v.ifl;
        ls_req = v.lsr; ls_we = v.lwe; ls_addr = v.lsa; ls_wdata = v.lwd;
        mem_rdata = v.mrd;
    endtask

    task automatic check_out(input string name, input vec_t v);
        n_chk++;
        if (mem_en !== v.en || mem_we !== v.we || mem_addr !== v.addr ||
            mem_wdata !== v.wd || if_ack !== v.ia || ls_ack !== v.la ||
            rd_data !== v.rdd || busy !== v.bsy) begin
            n_fail++;
            $display("FAIL %s: got en=%b we=%b addr=%h wd=%h ia=%b la=%b rd=%h busy=%b, want en=%b we=%b addr=%h wd=%h ia=%b la=%b rd=%h busy=%b",
                     name, mem_en, mem_we, mem_addr, mem_wdata, if_ack, ls_ack, rd_data, busy,
                     v.en, v.we, v.addr, v.wd, v.ia, v.la, v.rdd, v.bsy);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    // Advance to the start of the next cycle, just after the edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t z;
        z = mk(1, 0,16'h0,0, 0,0,16'h0,32'h0, 32'h0, 0,0,16'h0,32'h0, 0,0,32'h0,0);

        // 1: single fetch, LATENCY=2; held request masked in ack cycle
        vecs.push_back(mk(0, 1,16'h0100,0, 0,0,16'h0,32'h0, 32'h0,        0,0,16'h0000,32'h0, 0,0,32'h0,0));
        vecs.push_back(mk(0, 1,16'h0100,0, 0,0,16'h0,32'h0, 32'h0,        1,0,16'h0100,32'h0, 0,0,32'h0,1));
        vecs.push_back(mk(0, 1,16'h0100,0, 0,0,16'h0,32'h0, 32'hDEADBEEF, 1,0,16'h0100,32'h0, 0,0,32'h0,1));
        vecs.push_back(mk(0, 1,16'h0100,0, 0,0,16'h0,32'h0, 32'h0,        0,0,16'h0100,32'h0, 1,0,32'hDEADBEEF,0));
        vecs.push_back(mk(0, 0,16'h0,0,    0,0,16'h0,32'h0, 32'h0,        0,0,16'h0100,32'h0, 0,0,32'hDEADBEEF,0));
        // 2: data write; rd_data also captured on a write
        vecs.push_back(mk(0, 0,16'h0,0, 1,1,16'hFF00,32'h12345678, 32'h0,        0,0,16'h0100,32'h0,        0,0,32'hDEADBEEF,0));
        vecs.push_back(mk(0, 0,16'h0,0, 1,1,16'hFF00,32'h12345678, 32'h0,        1,1,16'hFF00,32'h12345678, 0,0,32'hDEADBEEF,1));
        vecs.push_back(mk(0, 0,16'h0,0, 1,1,16'hFF00,32'h12345678, 32'hCAFEF00D, 1,1,16'hFF00,32'h12345678, 0,0,32'hDEADBEEF,1));
        vecs.push_back(mk(0, 0,16'h0,0, 1,1,16'hFF00,32'h12345678, 32'h0,        0,0,16'hFF00,32'h12345678, 0,1,32'hCAFEF00D,0));
        vecs.push_back(mk(0, 0,16'h0,0, 0,0,16'h0,32'h0,           32'h0,        0,0,16'hFF00,32'h12345678, 0,0,32'hCAFEF00D,0));
        // 3: simultaneous requests: data first, fetch granted in the ls_ack cycle
        vecs.push_back(mk(0, 1,16'h0300,0, 1,0,16'h0400,32'h0, 32'h0,        0,0,16'hFF00,32'h12345678, 0,0,32'hCAFEF00D,0));
        vecs.push_back(mk(0, 1,16'h0300,0, 1,0,16'h0400,32'h0, 32'h0,        1,0,16'h0400,32'h0,        0,0,32'hCAFEF00D,1));
        vecs.push_back(mk(0, 1,16'h0300,0, 1,0,16'h0400,32'h0, 32'h11111111, 1,0,16'h0400,32'h0,        0,0,32'hCAFEF00D,1));
        vecs.push_back(mk(0, 1,16'h0300,0, 1,0,16'h0400,32'h0, 32'h0,        0,0,16'h0400,32'h0,        0,1,32'h11111111,0));
        vecs.push_back(mk(0, 1,16'h0300,0, 0,0,16'h0,32'h0,    32'h0,        1,0,16'h0300,32'h0,        0,0,32'h11111111,1));
        vecs.push_back(mk(0, 1,16'h0300,0, 0,0,16'h0,32'h0,    32'h22222222, 1,0,16'h0300,32'h0,        0,0,32'h11111111,1));
        vecs.push_back(mk(0, 1,16'h0300,0, 0,0,16'h0,32'h0,    32'h0,        0,0,16'h0300,32'h0,        1,0,32'h22222222,0));
        vecs.push_back(mk(0, 0,16'h0,0,    0,0,16'h0,32'h0,    32'h0,        0,0,16'h0300,32'h0,        0,0,32'h22222222,0));
        // 5: flush in flight drops if_ack, rd_data still updated; then refetch 0x0200
        vecs.push_back(mk(0, 1,16'h0500,0, 0,0,16'h0,32'h0, 32'h0,        0,0,16'h0300,32'h0, 0,0,32'h22222222,0));
        vecs.push_back(mk(0, 0,16'h0,1,    0,0,16'h0,32'h0, 32'h0,        1,0,16'h0500,32'h0, 0,0,32'h22222222,1));
        vecs.push_back(mk(0, 0,16'h0,0,    0,0,16'h0,32'h0, 32'h33333333, 1,0,16'h0500,32'h0, 0,0,32'h22222222,1));
        vecs.push_back(mk(0, 1,16'h0200,0, 0,0,16'h0,32'h0, 32'h0,        0,0,16'h0500,32'h0, 0,0,32'h33333333,0));
        vecs.push_back(mk(0, 1,16'h0200,0, 0,0,16'h0,32'h0, 32'h0,        1,0,16'h0200,32'h0, 0,0,32'h33333333,1));
        vecs.push_back(mk(0, 1,16'h0200,0, 0,0,16'h0,32'h0, 32'h44444444, 1,0,16'h0200,32'h0, 0,0,32'h33333333,1));
        vecs.push_back(mk(0, 1,16'h0200,0, 0,0,16'h0,32'h0, 32'h0,        0,0,16'h0200,32'h0, 1,0,32'h44444444,0));
        vecs.push_back(mk(0, 0,16'h0,0,    0,0,16'h0,32'h0, 32'h0,        0,0,16'h0200,32'h0, 0,0,32'h44444444,0));
        // flush in IDLE blocks the fetch grant for that cycle only
        vecs.push_back(mk(0, 1,16'h0600,1, 0,0,16'h0,32'h0, 32'h0,        0,0,16'h0200,32'h0, 0,0,32'h44444444,0));
        vecs.push_back(mk(0, 1,16'h0600,0, 0,0,16'h0,32'h0, 32'h0,        0,0,16'h0200,32'h0, 0,0,32'h44444444,0));
        vecs.push_back(mk(0, 1,16'h0600,0, 0,0,16'h0,32'h0, 32'h0,        1,0,16'h0600,32'h0, 0,0,32'h44444444,1));
        vecs.push_back(mk(0, 1,16'h0600,0, 0,0,16'h0,32'h0, 32'h55555555, 1,0,16'h0600,32'h0, 0,0,32'h44444444,1));
        vecs.push_back(mk(0, 0,16'h0,0,    0,0,16'h0,32'h0, 32'h0,        0,0,16'h0600,32'h0, 1,0,32'h55555555,0));
        vecs.push_back(mk(0, 0,16'h0,0,    0,0,16'h0,32'h0, 32'h0,        0,0,16'h0600,32'h0, 0,0,32'h55555555,0));
        // 6: reset during a write access aborts it, no ack
        vecs.push_back(mk(0, 0,16'h0,0, 1,1,16'h0700,32'hAAAA5555, 32'h0, 0,0,16'h0600,32'h0,        0,0,32'h55555555,0));
        vecs.push_back(mk(1, 0,16'h0,0, 1,1,16'h0700,32'hAAAA5555, 32'h0, 1,1,16'h0700,32'hAAAA5555, 0,0,32'h55555555,1));
        vecs.push_back(mk(0, 0,16'h0,0, 0,0,16'h0,32'h0,           32'h0, 0,0,16'h0000,32'h0,        0,0,32'h0,0));
        vecs.push_back(mk(0, 0,16'h0,0, 0,0,16'h0,32'h0,           32'h0, 0,0,16'h0000,32'h0,        0,0,32'h0,0));

        // reset and check reset state
        drive(z);
        next_cycle();
        next_cycle();
        @(negedge clk);
        check_out("reset_state", z);

        foreach (vecs[i]) begin
            next_cycle();
            drive(vecs[i]);
            @(negedge clk);
            check_out($sformatf("row%0d", i), vecs[i]);
        end

        // 4: both requests held; a flush in each ls_ack cycle keeps fetch from
        // being granted there, so data wins three times before starvation
        // forces the fetch grant.
        next_cycle();
        z.rst = 0;
        drive(z);
        if_req  = 1'b1; if_addr = 16'h0800;
        ls_req  = 1'b1; ls_we   = 1'b0; ls_addr = 16'h0900;
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 4; c++) begin
                if (c != 0) next_cycle();
                if_flush = (c == 3 && k < 3);
                @(negedge clk);
                if (c == 1) begin
                    check_val($sformatf("starve_grant%0d_en", k), {31'b0, mem_en}, 32'h1);
                    check_val($sformatf("starve_grant%0d_addr", k), {16'h0, mem_addr},
                              (k < 3) ? 32'h0900 : 32'h0800);
                end
                if (k == 3 && c == 0)
                    check_val("starve_cnt_sat", 32'(dut.starve_cnt), 32'd3);
                if (k == 3 && c == 1)
                    check_val("starve_cnt_clear", 32'(dut.starve_cnt), 32'd0);
            end
            if (k < 3) next_cycle();
        end
        if_req = 1'b0; ls_req = 1'b0; if_flush = 1'b0;
        next_cycle();
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
